// File: rtl/program_counter.sv
// SAP program counter: count, optional jump load, halt, gated bus drive.
// Define PC_LOAD_EN to compile in the lp/bus_in jump path.
module program_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             cp,
  input  logic             lp,
  input  logic             halt,
  input  logic             ep,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic do_inc;

`ifdef PC_LOAD_EN
  logic do_load;

  assign do_load = ~halt & lp;
  assign do_inc  = ~halt & ~lp & cp;
`else
  logic unused_load;

  assign unused_load = ^{lp, bus_in};
  assign do_inc      = ~halt & cp;
`endif

  // halt only gates the counter; bus_oe keeps tracking ep
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pc     <= RST;
      bus_oe <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      bus_oe <= ep;
      wrap   <= 1'b0;
      unique case (1'b1)
`ifdef PC_LOAD_EN
        do_load: pc <= bus_in;
`endif
        do_inc: begin
          pc   <= pc + WIDTH'(1);
          wrap <= &pc;
        end
        default: ;
      endcase
    end
  end

  assign bus_out = pc & {WIDTH{bus_oe}};

endmodule
